// File: rtl/instr_feeder_if.sv
// Host/processor-facing bus of the instruction feeder.
// The master side is the host plus processor model; the slave side is the feeder.
interface instr_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [15:0]       WrData;
  logic              Start;
  logic [ADDR_W:0]   Length;
  logic              Done;
  logic [15:0]       DIN;
  logic              Run;
  logic              Busy;
  logic              Finished;
  logic              Error;
  logic [ADDR_W-1:0] PC;
  logic [7:0]        InstrCount;

  modport master (
    output WrEn, WrAddr, WrData, Start, Length, Done,
    input  DIN, Run, Busy, Finished, Error, PC, InstrCount
  );

  modport slave (
    input  WrEn, WrAddr, WrData, Start, Length, Done,
    output DIN, Run, Busy, Finished, Error, PC, InstrCount
  );
endinterface

// File: rtl/instr_feeder.sv
// Instruction sequencer: replays a preloaded program buffer into the
// processor's DIN/Run inputs, waiting on Done after each instruction.
module instr_feeder #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input logic          Clock,
  input logic          Reset,
  instr_feeder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, FINISH, ERR} state_t;

  localparam logic [2:0] OP_MVI      = 3'b001;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t            state, state_next;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W:0]   rem, rem_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [7:0]        tcnt, tcnt_next;
  logic [7:0]        instr_count;
  logic [15:0]       din;
  logic              run;
  logic              launch;
  logic              complete;
  logic              busy;

  // ERR is not busy so the host may reload the buffer after a timeout.
  assign busy = (state != IDLE) && (state != ERR);

  // Program buffer write port; reads are asynchronous below.
  // NOTE: the buffer has no reset on purpose -- a program must survive Reset,
  // and leaving it out lets the array map onto plain RAM.
  always_ff @(posedge Clock) begin
    if (bus.WrEn && !busy) mem[bus.WrAddr] <= bus.WrData;
  end

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic plus next values of PC, remaining-word and timeout counters.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    rem_next   = rem;
    tcnt_next  = '0;
    launch     = 1'b0;
    complete   = 1'b0;

    case (state)
      IDLE, ERR: begin
        if (bus.Start) begin
          if (bus.Length != '0) begin
            launch     = 1'b1;
            pc_next    = '0;
            rem_next   = bus.Length;
            state_next = ISSUE;
          end else begin
            state_next = FINISH;
          end
        end
      end

      ISSUE: begin
        // Done is not looked at here: the processor cannot finish in the issue cycle.
        rem_next = rem - 1'b1;
        if (din[15:13] == OP_MVI) begin
          pc_next    = pc + 1'b1;
          state_next = IMM;
        end else begin
          state_next = WAIT;
        end
      end

      IMM: begin
        // A trailing mvi past the counted length still fetches its immediate,
        // so the remaining count saturates instead of wrapping.
        rem_next = (rem == '0) ? '0 : rem - 1'b1;
        if (bus.Done) complete   = 1'b1;
        else          state_next = WAIT;
      end

      WAIT: begin
        // Done takes priority over a timeout expiring in the same cycle.
        if (bus.Done)                 complete   = 1'b1;
        else if (tcnt >= TIMEOUT_CNT) state_next = ERR;
        else                          tcnt_next  = tcnt + 1'b1;
      end

      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (complete) begin
      if (rem_next == '0) begin
        state_next = FINISH;
      end else begin
        pc_next    = pc + 1'b1;
        state_next = ISSUE;
      end
    end
  end

  // Datapath registers: DIN/Run are loaded on the edge that enters ISSUE or IMM.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      din         <= '0;
      run         <= 1'b0;
      pc          <= '0;
      rem         <= '0;
      tcnt        <= '0;
      instr_count <= '0;
    end else begin
      pc   <= pc_next;
      rem  <= rem_next;
      tcnt <= tcnt_next;
      run  <= (state_next == ISSUE);
      if (state_next == ISSUE || state_next == IMM) din <= mem[pc_next];
      if (launch)        instr_count <= '0;
      else if (complete) instr_count <= instr_count + 1'b1;
    end
  end

  assign bus.DIN        = din;
  assign bus.Run        = run;
  assign bus.Busy       = busy;
  assign bus.Finished   = (state == FINISH);
  assign bus.Error      = (state == ERR);
  assign bus.PC         = pc;
  assign bus.InstrCount = instr_count;

endmodule
